uart_frame_parser: RTL and testbench

Byte-stream framer between the UART receiver's byte outputs (rx_data/rx_ready) and control_top. It hunts for a start-of-frame byte, then collects command, length and payload bytes and verifies an XOR checksum. Each verified frame is presented as one parallel command word, held until the consumer acknowledges it. Malformed, truncated or overrun frames are dropped, flagged with one-cycle error pulses and counted.

---
 rtl/uart_frame_pkg.sv | 24 ++
 rtl/uart_frame_parser_timer.sv | 31 +++
 rtl/uart_frame_parser.sv | 191 +++++++++++++++++++
 tb/tb_uart_frame_parser.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types and defaults for the UART frame parser.
// Also holds the saturating counter increment used by the parser.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        LEN,
        PAYLOAD,
        CHK,
        HOLD
    } state_t;

    localparam logic [7:0]  DEFAULT_SOF         = 8'hA5;
    localparam int unsigned DEFAULT_MAX_PAYLOAD = 8;
    localparam int unsigned DEFAULT_LEN_W       = 4;
    localparam int unsigned DEFAULT_TIMEOUT     = 10000;

    // Saturating increment for 8-bit event counters
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_frame_parser_timer.sv
// Inter-byte idle timer: counts clocks while enabled and not cleared.
// expire_c is high for the single cycle in which the count sits at TIMEOUT_CYCLES-1.
module byte_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 10000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear || !enable) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // A byte arriving on the expiry cycle wins over the timeout
    assign expire_c = enable && !clear && (cnt == LAST);

endmodule

// File: rtl/uart_frame_parser.sv
// Frames the UART byte stream: SOF, CMD, LEN, payload, XOR checksum.
// Verified frames are held on frame_* until acknowledged; faults pulse err_* and are counted.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD    = DEFAULT_MAX_PAYLOAD,
    parameter int unsigned LEN_W          = DEFAULT_LEN_W,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter logic [7:0]  SOF_BYTE       = DEFAULT_SOF
) (
    input  logic                     MAX10_CLK1_50,
    input  logic                     reset,
    input  logic [7:0]               rx_data,
    input  logic                     rx_ready,
    output logic                     frame_valid,
    output logic [7:0]               frame_cmd,
    output logic [LEN_W-1:0]         frame_len,
    output logic [8*MAX_PAYLOAD-1:0] frame_payload,
    input  logic                     frame_ack,
    output logic                     err_chk,
    output logic                     err_len,
    output logic                     err_timeout,
    output logic                     err_overrun,
    output logic [7:0]               good_cnt,
    output logic [7:0]               bad_cnt
);

    state_t state, state_d;

    logic [7:0]               cmd_q;
    logic [7:0]               xor_q;
    logic [LEN_W-1:0]         len_q;
    logic [LEN_W-1:0]         idx_q;
    logic [8*MAX_PAYLOAD-1:0] payload_q;

    logic latch_cmd, latch_len, store_byte, accept;
    logic err_chk_d, err_len_d, err_timeout_d, err_overrun_d;
    logic timer_en_c, expire_c;

    assign timer_en_c = (state == CMD) || (state == LEN) || (state == PAYLOAD) || (state == CHK);

    byte_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (MAX10_CLK1_50),
        .reset    (reset),
        .clear    (rx_ready),
        .enable   (timer_en_c),
        .expire_c (expire_c)
    );

    always_ff @(posedge MAX10_CLK1_50) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and datapath strobes
    always_comb begin
        state_d       = state;
        latch_cmd     = 1'b0;
        latch_len     = 1'b0;
        store_byte    = 1'b0;
        accept        = 1'b0;
        err_chk_d     = 1'b0;
        err_len_d     = 1'b0;
        err_timeout_d = 1'b0;
        err_overrun_d = 1'b0;
        case (state)
            IDLE: begin
                if (rx_ready && (rx_data == SOF_BYTE)) begin
                    state_d = CMD;
                end
            end
            CMD: begin
                if (expire_c) begin
                    err_timeout_d = 1'b1;
                    state_d       = IDLE;
                end else if (rx_ready) begin
                    latch_cmd = 1'b1;
                    state_d   = LEN;
                end
            end
            LEN: begin
                if (expire_c) begin
                    err_timeout_d = 1'b1;
                    state_d       = IDLE;
                end else if (rx_ready) begin
                    if (rx_data > 8'(MAX_PAYLOAD)) begin
                        err_len_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        latch_len = 1'b1;
                        state_d   = (rx_data == 8'd0) ? CHK : PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (expire_c) begin
                    err_timeout_d = 1'b1;
                    state_d       = IDLE;
                end else if (rx_ready) begin
                    store_byte = 1'b1;
                    if (idx_q == (len_q - LEN_W'(1))) begin
                        state_d = CHK;
                    end
                end
            end
            CHK: begin
                if (expire_c) begin
                    err_timeout_d = 1'b1;
                    state_d       = IDLE;
                end else if (rx_ready) begin
                    if (rx_data == xor_q) begin
                        accept  = 1'b1;
                        state_d = HOLD;
                    end else begin
                        err_chk_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            HOLD: begin
                // Bytes are never consumed here, even on the ack cycle
                err_overrun_d = rx_ready;
                if (frame_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge MAX10_CLK1_50) begin
        if (!reset) begin
            cmd_q         <= '0;
            xor_q         <= '0;
            len_q         <= '0;
            idx_q         <= '0;
            payload_q     <= '0;
            frame_valid   <= 1'b0;
            frame_cmd     <= '0;
            frame_len     <= '0;
            frame_payload <= '0;
            err_chk       <= 1'b0;
            err_len       <= 1'b0;
            err_timeout   <= 1'b0;
            err_overrun   <= 1'b0;
            good_cnt      <= '0;
            bad_cnt       <= '0;
        end else begin
            frame_valid <= (state_d == HOLD);
            err_chk     <= err_chk_d;
            err_len     <= err_len_d;
            err_timeout <= err_timeout_d;
            err_overrun <= err_overrun_d;

            if (latch_cmd) begin
                cmd_q <= rx_data;
                xor_q <= rx_data;
            end
            if (latch_len) begin
                len_q     <= LEN_W'(rx_data);
                xor_q     <= xor_q ^ rx_data;
                idx_q     <= '0;
                payload_q <= '0;
            end
            if (store_byte) begin
                for (int unsigned i = 0; i < MAX_PAYLOAD; i++) begin
                    if (idx_q == LEN_W'(i)) begin
                        payload_q[8*i +: 8] <= rx_data;
                    end
                end
                xor_q <= xor_q ^ rx_data;
                idx_q <= idx_q + LEN_W'(1);
            end
            if (accept) begin
                frame_cmd     <= cmd_q;
                frame_len     <= len_q;
                frame_payload <= payload_q;
                good_cnt      <= sat_inc8(good_cnt);
            end
            if (err_chk_d || err_len_d || err_timeout_d || err_overrun_d) begin
                bad_cnt <= sat_inc8(bad_cnt);
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: a frame-level model predicts every
// output event (frame, release, error pulses) with its clock edge; a monitor checks them.
module tb_uart_frame_parser;

    localparam int unsigned MAXP = 8;
    localparam int unsigned LW   = 4;
    localparam int unsigned TMO  = 100;
    localparam logic [7:0]  SOF  = 8'hA5;

    localparam int K_FRAME = 0;
    localparam int K_DROP  = 1;
    localparam int K_CHK   = 2;
    localparam int K_LEN   = 3;
    localparam int K_TO    = 4;
    localparam int K_OVR   = 5;

    typedef struct {
        int                  kind;
        int                  edge_n;
        logic [7:0]          cmd;
        logic [LW-1:0]       len;
        logic [8*MAXP-1:0]   pl;
    } ev_t;

    typedef logic [7:0] bytes_t[$];

    logic                clk = 1'b0;
    logic                reset;
    logic [7:0]          rx_data;
    logic                rx_ready;
    logic                frame_ack;
    logic                frame_valid;
    logic [7:0]          frame_cmd;
    logic [LW-1:0]       frame_len;
    logic [8*MAXP-1:0]   frame_payload;
    logic                err_chk, err_len, err_timeout, err_overrun;
    logic [7:0]          good_cnt, bad_cnt;

    int tests = 0;
    int fails = 0;
    int edge_cnt = 0;
    ev_t exp_q[$];

    uart_frame_parser #(
        .MAX_PAYLOAD   (MAXP),
        .LEN_W         (LW),
        .TIMEOUT_CYCLES(TMO),
        .SOF_BYTE      (SOF)
    ) dut (
        .MAX10_CLK1_50(clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .frame_valid  (frame_valid),
        .frame_cmd    (frame_cmd),
        .frame_len    (frame_len),
        .frame_payload(frame_payload),
        .frame_ack    (frame_ack),
        .err_chk      (err_chk),
        .err_len      (err_len),
        .err_timeout  (err_timeout),
        .err_overrun  (err_overrun),
        .good_cnt     (good_cnt),
        .bad_cnt      (bad_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        if (edge_cnt > 60000) begin
            $display("FAIL watchdog: edge %0d exceeded budget 60000", edge_cnt);
            $fatal(1);
        end
    end

    // ---------------- reference model (frame level) ----------------
    bit         m_in;
    bit         m_held;
    logic [7:0] m_pend[$];
    int         m_last;
    int         m_good;
    int         m_bad;

    task automatic m_push(input int kind, input int n, input logic [7:0] c,
                          input logic [LW-1:0] l, input logic [8*MAXP-1:0] p);
        ev_t e;
        e.kind = kind; e.edge_n = n; e.cmd = c; e.len = l; e.pl = p;
        exp_q.push_back(e);
    endtask

    task automatic m_err(input int kind, input int n);
        m_push(kind, n, 8'h00, '0, '0);
        if (m_bad < 255) m_bad++;
    endtask

    // A frame in progress times out TMO edges after its last byte if nothing arrived
    task automatic m_timeout(input int now);
        if (m_in && (m_last + int'(TMO) <= now)) begin
            m_err(K_TO, m_last + int'(TMO));
            m_in = 1'b0;
        end
    endtask

    task automatic m_complete(input int n);
        logic [7:0]        x;
        logic [8*MAXP-1:0] p;
        int                len;
        x   = 8'h00;
        p   = '0;
        len = int'(m_pend[1]);
        for (int i = 0; i < m_pend.size() - 1; i++) x ^= m_pend[i];
        for (int i = 0; i < len; i++) p[8*i +: 8] = m_pend[2+i];
        if (x == m_pend[m_pend.size()-1]) begin
            m_push(K_FRAME, n, m_pend[0], LW'(len), p);
            m_held = 1'b1;
            if (m_good < 255) m_good++;
        end else begin
            m_err(K_CHK, n);
        end
        m_in = 1'b0;
    endtask

    task automatic m_cycle(input bit rdy, input logic [7:0] d, input bit ack, input int n);
        bit was_held;
        if (rdy) m_timeout(n - 1); else m_timeout(n);
        was_held = m_held;
        if (m_held && ack) begin
            m_held = 1'b0;
            m_push(K_DROP, n, 8'h00, '0, '0);
        end
        if (rdy) begin
            if (was_held) begin
                m_err(K_OVR, n);
            end else if (!m_in) begin
                if (d == SOF) begin
                    m_in = 1'b1;
                    m_pend.delete();
                    m_last = n;
                end
            end else begin
                m_pend.push_back(d);
                m_last = n;
                if (m_pend.size() == 2 && int'(d) > int'(MAXP)) begin
                    m_err(K_LEN, n);
                    m_in = 1'b0;
                end else if (m_pend.size() >= 2 && m_pend.size() == int'(m_pend[1]) + 3) begin
                    m_complete(n);
                end
            end
        end
    endtask

    task automatic m_reset(input int n);
        if (m_held) m_push(K_DROP, n, 8'h00, '0, '0);
        m_in = 1'b0; m_held = 1'b0; m_good = 0; m_bad = 0;
        m_pend.delete();
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_ev(input int kind);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL event: got kind %0d at edge %0d, expected no event", kind, edge_cnt);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || e.edge_n != edge_cnt) begin
            fails++;
            $display("FAIL event: got kind %0d at edge %0d, expected kind %0d at edge %0d",
                     kind, edge_cnt, e.kind, e.edge_n);
        end else if (kind == K_FRAME &&
                     (frame_cmd !== e.cmd || frame_len !== e.len || frame_payload !== e.pl)) begin
            fails++;
            $display("FAIL frame_data: got cmd %h len %0d pl %h expected cmd %h len %0d pl %h",
                     frame_cmd, frame_len, frame_payload, e.cmd, e.len, e.pl);
        end
    endtask

    logic              pv = 1'b0;
    logic [7:0]        h_cmd;
    logic [LW-1:0]     h_len;
    logic [8*MAXP-1:0] h_pl;

    always @(negedge clk) begin
        if (frame_valid && !pv) begin
            check_ev(K_FRAME);
            h_cmd <= frame_cmd;
            h_len <= frame_len;
            h_pl  <= frame_payload;
        end else if (frame_valid && pv) begin
            tests++;
            if (frame_cmd !== h_cmd || frame_len !== h_len || frame_payload !== h_pl) begin
                fails++;
                $display("FAIL hold_stable: got cmd %h len %0d pl %h expected cmd %h len %0d pl %h",
                         frame_cmd, frame_len, frame_payload, h_cmd, h_len, h_pl);
            end
        end
        if (!frame_valid && pv) check_ev(K_DROP);
        if (err_chk)     check_ev(K_CHK);
        if (err_len)     check_ev(K_LEN);
        if (err_timeout) check_ev(K_TO);
        if (err_overrun) check_ev(K_OVR);
        pv <= frame_valid;
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit rdy, input logic [7:0] d, input bit ack);
        int n;
        n = edge_cnt + 1;
        m_cycle(rdy, d, ack, n);
        rx_ready  = rdy;
        rx_data   = d;
        frame_ack = ack;
        @(negedge clk);
        rx_ready  = 1'b0;
        frame_ack = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) cyc(1'b0, 8'h00, 1'b0);
    endtask

    task automatic send_pk(input logic [127:0] v, input int nb, input int gap);
        for (int i = 0; i < nb; i++) begin
            cyc(1'b1, v[8*(nb-1-i) +: 8], 1'b0);
            idle(gap);
        end
    endtask

    task automatic do_reset();
        m_reset(edge_cnt + 1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic random_frame();
        bytes_t     q;
        int         kind;
        int         len;
        logic [7:0] x;
        logic [7:0] b;
        logic [7:0] cmd;
        kind = int'($urandom_range(0, 9));
        repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom);
            if (b == SOF) b = 8'h00;
            cyc(1'b1, b, $urandom_range(0, 3) == 0);
        end
        cmd = 8'($urandom);
        len = (kind == 9) ? int'($urandom_range(MAXP + 1, 15)) : int'($urandom_range(0, MAXP));
        q.push_back(SOF);
        q.push_back(cmd);
        q.push_back(8'(len));
        x = cmd ^ 8'(len);
        if (kind != 9) begin
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom);
                q.push_back(b);
                x ^= b;
            end
            if (kind == 8) x ^= 8'(1 << $urandom_range(0, 7));
            q.push_back(x);
        end
        if (kind == 7) begin
            len = int'($urandom_range(1, q.size() - 1));
            while (q.size() > len) void'(q.pop_back());
        end
        foreach (q[i]) begin
            cyc(1'b1, q[i], 1'b0);
            idle(int'($urandom_range(0, 2)));
        end
        if (kind == 7) idle(int'(TMO) + 3);
        if (m_held) begin
            idle(int'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0) cyc(1'b1, 8'($urandom), 1'b0);
            cyc($urandom_range(0, 2) == 0, 8'($urandom), 1'b1);
        end
        idle(1);
        chk("good_cnt_rand", 128'(good_cnt), 128'(m_good));
        chk("bad_cnt_rand", 128'(bad_cnt), 128'(m_bad));
    endtask

    initial begin
        reset     = 1'b0;
        rx_ready  = 1'b0;
        rx_data   = 8'h00;
        frame_ack = 1'b0;
        m_in = 1'b0; m_held = 1'b0; m_last = 0; m_good = 0; m_bad = 0;
        repeat (2) @(negedge clk);
        chk("reset_state", {frame_valid, frame_cmd, frame_len, frame_payload,
                            err_chk, err_len, err_timeout, err_overrun, good_cnt, bad_cnt}, '0);
        reset = 1'b1;
        idle(2);

        // good frame, held then acked
        send_pk(128'hA5_10_03_11_22_33_13, 7, 0);
        chk("good_valid", 128'(frame_valid), 128'(1));
        chk("good_cmd", 128'(frame_cmd), 128'h10);
        chk("good_len", 128'(frame_len), 128'(3));
        chk("good_payload", 128'(frame_payload), 128'h332211);
        chk("good_cnt_1", 128'(good_cnt), 128'(1));
        idle(20);
        chk("hold_valid", 128'(frame_valid), 128'(1));
        cyc(1'b0, 8'h00, 1'b1);
        chk("ack_release", 128'(frame_valid), 128'(0));

        // checksum error, then zero-length frame
        send_pk(128'hA5_10_03_11_22_33_14, 7, 1);
        chk("badchk_cnt", 128'(bad_cnt), 128'(1));
        chk("badchk_valid", 128'(frame_valid), 128'(0));
        send_pk(128'hA5_05_00_05, 4, 0);
        chk("len0_cmd", 128'(frame_cmd), 128'h05);
        chk("len0_len", 128'(frame_len), 128'(0));
        chk("len0_payload", 128'(frame_payload), 128'(0));
        cyc(1'b0, 8'h00, 1'b1);

        // length error, then single-byte frame
        send_pk(128'hA5_20_09, 3, 0);
        chk("lenerr_cnt", 128'(bad_cnt), 128'(2));
        send_pk(128'hA5_01_01_AA_AA, 5, 0);
        chk("len1_payload", 128'(frame_payload[7:0]), 128'hAA);
        cyc(1'b0, 8'h00, 1'b1);

        // timeout after CMD, then recovery
        send_pk(128'hA5_10, 2, 0);
        idle(int'(TMO) + 5);
        chk("timeout_cnt", 128'(bad_cnt), 128'(3));
        send_pk(128'hA5_07_01_42_44, 5, 1);
        chk("after_to_valid", 128'(frame_valid), 128'(1));
        cyc(1'b0, 8'h00, 1'b1);

        // gap of TMO-1 idle cycles is still inside the window
        send_pk(128'hA5_10, 2, 0);
        idle(int'(TMO) - 1);
        send_pk(128'h03_11_22_33_13, 5, 0);
        chk("edge_gap_valid", 128'(frame_valid), 128'(1));
        cyc(1'b0, 8'h00, 1'b1);

        // overrun during HOLD, and byte coincident with ack
        send_pk(128'hA5_10_03_11_22_33_13, 7, 0);
        cyc(1'b1, 8'h55, 1'b0);
        chk("ovr_valid", 128'(frame_valid), 128'(1));
        chk("ovr_payload", 128'(frame_payload), 128'h332211);
        cyc(1'b1, 8'h66, 1'b1);
        chk("ovr_ack_release", 128'(frame_valid), 128'(0));
        idle(3);
        chk("ovr_bad_cnt", 128'(bad_cnt), 128'(m_bad));

        // noise before SOF, then reset mid-frame
        send_pk(128'h00_FF_3C, 3, 0);
        chk("noise_bad_cnt", 128'(bad_cnt), 128'(m_bad));
        send_pk(128'hA5_10_03_11_22, 5, 0);
        do_reset();
        chk("midreset_outputs", {frame_valid, frame_cmd, frame_len, frame_payload,
                                 err_chk, err_len, err_timeout, err_overrun, good_cnt, bad_cnt}, '0);
        send_pk(128'hA5_10_03_11_22_33_13, 7, 0);
        chk("post_reset_good", 128'(good_cnt), 128'(1));
        cyc(1'b0, 8'h00, 1'b1);

        for (int f = 0; f < 150; f++) random_frame();

        // bad_cnt saturation
        for (int f = 0; f < 300; f++) send_pk(128'hA5_20_09, 3, 0);
        idle(2);
        chk("bad_cnt_sat", 128'(bad_cnt), 128'hFF);

        idle(5);
        chk("events_drained", 128'(exp_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
